// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed little-endian byte stream
// and writes 32-bit words into the instruction memory.
module imem_loader #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  output logic        WriteEnable,
  output logic [31:0] WriteAddress,
  output logic [31:0] WriteData,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error
);

  localparam int          IW   = $clog2(MEM_WORDS) + 1;
  localparam logic [31:0] MAXW = 32'(MEM_WORDS);
  localparam logic [IW-1:0] ONE = IW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_CHECK, S_DATA,
    S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t        state, next;
  logic [1:0]    byte_cnt;
  logic [IW-1:0] index;
  logic [31:0]   count;
  logic [23:0]   acc;
  logic          xfer;
  logic          start_go;
  logic          last_byte;
  logic [31:0]   index32;

  assign RxReady   = (state == S_COUNT) || (state == S_DATA);
  assign xfer      = RxValid && RxReady;
  assign last_byte = (byte_cnt == 2'd3);
  assign index32   = {{(32-IW){1'b0}}, index};

  always_comb begin
    next        = state;
    WriteEnable = 1'b0;
    CpuHold     = 1'b0;
    Done        = 1'b0;
    Error       = 1'b0;
    start_go    = 1'b0;
    case (state)
      S_IDLE: begin
        start_go = Start;
        if (Start) next = S_COUNT;
      end
      S_COUNT: begin
        CpuHold = 1'b1;
        if (xfer && last_byte) next = S_CHECK;
      end
      S_CHECK: begin
        CpuHold = 1'b1;
        if (count > MAXW)        next = S_ERROR;
        else if (count == 32'd0) next = S_DONE;
        else                     next = S_DATA;
      end
      S_DATA: begin
        CpuHold = 1'b1;
        if (xfer && last_byte) next = S_WRITE;
      end
      S_WRITE: begin
        CpuHold     = 1'b1;
        WriteEnable = 1'b1;
        // index has not advanced yet, so compare against index+1
        if (index32 + 32'd1 == count) next = S_DONE;
        else                          next = S_DATA;
      end
      S_DONE: begin
        Done     = 1'b1;
        start_go = Start;
        if (Start) next = S_COUNT;
      end
      S_ERROR: begin
        Error    = 1'b1;
        start_go = Start;
        if (Start) next = S_COUNT;
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      byte_cnt     <= 2'd0;
      index        <= '0;
      count        <= 32'd0;
      acc          <= 24'd0;
      WriteAddress <= BASE_ADDR;
      WriteData    <= 32'd0;
    end else begin
      state <= next;
      if (start_go) begin
        byte_cnt <= 2'd0;
        index    <= '0;
        count    <= 32'd0;
      end
      if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == S_COUNT) begin
          count <= {RxData, count[31:8]};
        end else begin
          acc <= {RxData, acc[23:8]};
          if (last_byte) begin
            WriteData    <= {RxData, acc};
            WriteAddress <= BASE_ADDR + (index32 << 2);
          end
        end
      end
      if (state == S_WRITE) index <= index + ONE;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: images, boundaries, reset, Start.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  RxData = 8'h00;
  logic        RxValid = 1'b0;
  logic        RxReady;
  logic        WriteEnable;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_xfer_cyc = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  bit watch_hold = 0;
  bit hold_drop = 0;

  imem_loader #(.MEM_WORDS(4096), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .Start(Start),
    .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
    .WriteEnable(WriteEnable), .WriteAddress(WriteAddress),
    .WriteData(WriteData), .CpuHold(CpuHold),
    .Done(Done), .Error(Error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (WriteEnable) begin
      wa.push_back(WriteAddress);
      wd.push_back(WriteData);
    end
    if (watch_hold && !CpuHold && !Done) hold_drop = 1;
  end

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    RxData  = b;
    RxValid = 1'b1;
    while (!RxReady && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL rxready_timeout got RxReady=%b want 1", RxReady);
    end
    @(negedge clk);
    last_xfer_cyc = cyc;
    RxValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (!Done && g < 50) begin
      @(negedge clk);
      g++;
    end
    vectors++;
    if (!Done) begin
      miscompares++;
      $display("FAIL done_timeout got Done=%b want 1", Done);
    end
  endtask

  task automatic check_two_writes(input string tag);
    vectors++;
    if (wa.size() !== 2) begin
      miscompares++;
      $display("FAIL %s_wcount got %0d want 2", tag, wa.size());
    end
    if (wa.size() == 2) begin
      vectors++;
      if (wa[0] !== 32'h0 || wd[0] !== 32'h0000_0013) begin
        miscompares++;
        $display("FAIL %s_w0 got %h/%h want 0/00000013", tag, wa[0], wd[0]);
      end
      vectors++;
      if (wa[1] !== 32'h4 || wd[1] !== 32'h0010_0093) begin
        miscompares++;
        $display("FAIL %s_w1 got %h/%h want 4/00100093", tag, wa[1], wd[1]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({RxReady, WriteEnable, CpuHold, Done, Error} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 00000",
               {RxReady, WriteEnable, CpuHold, Done, Error});
    end
    vectors++;
    if (WriteAddress !== 32'h0 || WriteData !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_bus got %h/%h want 0/0", WriteAddress, WriteData);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int first;
    int dcyc;
    wa.delete();
    wd.delete();
    pulse_start();
    watch_hold = 1;
    hold_drop  = 0;
    vectors++;
    if (CpuHold !== 1'b1 || RxReady !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_count_state got hold=%b rdy=%b want 1/1",
               CpuHold, RxReady);
    end
    send_byte(8'h02);
    first = last_xfer_cyc;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    wait_done();
    dcyc = cyc - first + 1;
    watch_hold = 0;
    vectors++;
    if (dcyc !== 15) begin
      miscompares++;
      $display("FAIL basic_done_cycle got %0d want 15", dcyc);
    end
    vectors++;
    if (hold_drop !== 1'b0 || CpuHold !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_hold got drop=%b hold=%b want 0/0",
               hold_drop, CpuHold);
    end
    check_two_writes("basic");
  endtask

  task automatic test_gaps();
    wa.delete();
    wd.delete();
    pulse_start();
    send_word(32'd2, 1);
    send_word(32'h0000_0013, 1);
    send_word(32'h0010_0093, 1);
    wait_done();
    check_two_writes("gaps");
  endtask

  task automatic test_zero();
    wa.delete();
    wd.delete();
    pulse_start();
    send_word(32'd0, 0);
    vectors++;
    if (Done !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_check_cycle got Done=%b want 0", Done);
    end
    @(negedge clk);
    vectors++;
    if (Done !== 1'b1 || wa.size() !== 0) begin
      miscompares++;
      $display("FAIL zero_done got Done=%b writes=%0d want 1/0",
               Done, wa.size());
    end
  endtask

  task automatic test_max();
    wa.delete();
    wd.delete();
    pulse_start();
    send_word(32'd4096, 0);
    for (int i = 0; i < 4096; i++)
      send_word(32'h1000_0000 + i, 0);
    wait_done();
    vectors++;
    if (wa.size() !== 4096) begin
      miscompares++;
      $display("FAIL max_wcount got %0d want 4096", wa.size());
    end
    if (wa.size() == 4096) begin
      vectors++;
      if (wa[4095] !== 32'h3FFC || wd[4095] !== 32'h1000_0FFF) begin
        miscompares++;
        $display("FAIL max_last got %h/%h want 00003ffc/10000fff",
                 wa[4095], wd[4095]);
      end
      vectors++;
      if (wa[100] !== 32'h190 || wd[100] !== 32'h1000_0064) begin
        miscompares++;
        $display("FAIL max_mid got %h/%h want 00000190/10000064",
                 wa[100], wd[100]);
      end
    end
  endtask

  task automatic test_overflow();
    wa.delete();
    wd.delete();
    pulse_start();
    send_word(32'd4097, 0);
    @(negedge clk);
    vectors++;
    if ({Error, Done, RxReady, CpuHold} !== 4'b1000 || wa.size() !== 0) begin
      miscompares++;
      $display("FAIL overflow got err/done/rdy/hold=%b writes=%0d want 1000/0",
               {Error, Done, RxReady, CpuHold}, wa.size());
    end
  endtask

  task automatic test_reset_mid();
    wa.delete();
    wd.delete();
    pulse_start();
    send_word(32'd1, 0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    #1;
    vectors++;
    if ({RxReady, WriteEnable, CpuHold, Done, Error} !== 5'b0) begin
      miscompares++;
      $display("FAIL midrst_flags got %b want 00000",
               {RxReady, WriteEnable, CpuHold, Done, Error});
    end
    vectors++;
    if (WriteAddress !== 32'h0 || WriteData !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_bus got %h/%h want 0/0", WriteAddress, WriteData);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (wa.size() !== 0) begin
      miscompares++;
      $display("FAIL midrst_nowrite got %0d want 0", wa.size());
    end
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    wait_done();
    check_two_writes("midrst_reload");
  endtask

  task automatic test_start_ignored();
    wa.delete();
    wd.delete();
    pulse_start();
    send_word(32'd2, 0);
    send_byte(8'h13);
    send_byte(8'h00);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_word(32'h0010_0093, 0);
    // now in the final WRITE cycle
    pulse_start();
    vectors++;
    if (Done !== 1'b1 || CpuHold !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_write got done=%b hold=%b want 1/0",
               Done, CpuHold);
    end
    check_two_writes("start_ign");
    pulse_start();
    vectors++;
    if (Done !== 1'b0 || CpuHold !== 1'b1 || RxReady !== 1'b1) begin
      miscompares++;
      $display("FAIL restart got done=%b hold=%b rdy=%b want 0/1/1",
               Done, CpuHold, RxReady);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero();
    test_overflow();
    test_reset_mid();
    test_start_ignored();
    test_max();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
